// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one shared saturating multiply/accumulate lane walks taps 0..TAPS-1 in order.
// Result registers TAPS cycles after accept and is held until out_ready; inputs are refused while busy.
module fir_tap_sequencer #(
   parameter int TAPS = 4,
   parameter int W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TAPS*W-1:0] coefs,
   input  logic [W-1:0]      in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W-1:0] MAXV_WIDE = {{(W+1){1'b0}}, {(W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t              r_state;
   logic signed [W-1:0] r_x [TAPS];
   logic signed [W-1:0] r_c [TAPS];
   logic [W-1:0]        r_acc;
   logic [IW-1:0]       r_idx;

   logic                  w_accept;
   logic signed [2*W-1:0] w_cw;
   logic signed [2*W-1:0] w_xw;
   logic signed [2*W-1:0] w_prod;
   logic signed [2*W-1:0] w_shift;
   logic [W-1:0]          w_mul;
   logic [W:0]            w_sum;
   logic [W-1:0]          w_sum_sat;

   assign in_ready = (r_state == IDLE) && !rst;
   assign w_accept = in_valid && in_ready;

   // Only min*min can exceed the positive range after the Q-format shift.
   always_comb begin
      w_cw    = {{W{r_c[r_idx][W-1]}}, r_c[r_idx]};
      w_xw    = {{W{r_x[r_idx][W-1]}}, r_x[r_idx]};
      w_prod  = w_cw * w_xw;
      w_shift = w_prod >>> (W-1);
      w_mul   = (w_shift > MAXV_WIDE) ? MAXV : w_shift[W-1:0];
      w_sum   = {r_acc[W-1], r_acc} + {w_mul[W-1], w_mul};
      if (w_sum[W] ^ w_sum[W-1]) begin
         w_sum_sat = r_acc[W-1] ? MINV : MAXV;
      end else begin
         w_sum_sat = w_sum[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         for (int k = 0; k < TAPS; k++) begin
            r_x[k] <= '0;
            r_c[k] <= '0;
         end
         r_acc     <= '0;
         r_idx     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x[0] <= in_data;
                  for (int k = 1; k < TAPS; k++) begin
                     r_x[k] <= r_x[k-1];
                  end
                  for (int k = 0; k < TAPS; k++) begin
                     r_c[k] <= coefs[k*W +: W];
                  end
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               r_acc <= w_sum_sat;
               if (r_idx == IW'(TAPS-1)) begin
                  r_idx     <= '0;
                  out_data  <= w_sum_sat;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: transaction-level reference model plus directed and randomized stimulus.
module tb_fir_tap_sequencer;
   localparam int TAPS = 4;
   localparam int W    = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [TAPS*W-1:0] coefs;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      out_data;
   logic              out_valid;
   logic              out_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fir_tap_sequencer #(.TAPS(TAPS), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .coefs     (coefs),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Reference: a sample in flight from accept until the output handshake,
   // result visible TAPS edges after accept.
   int          m_x [TAPS];
   bit          m_busy     = 1'b0;
   bit          m_have_out = 1'b0;
   logic [15:0] m_exp      = '0;
   int          m_acc_cyc  = 0;
   int          cyc        = 0;
   logic [15:0] got_q [$];

   function automatic int clamp16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] fir_ref(input logic [TAPS*W-1:0] cv, input int xv [TAPS]);
      int acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         int c;
         int p;
         int s;
         c = $signed(cv[k*W +: W]);
         p = c * xv[k];
         s = p >>> (W-1);
         if (s > 32767) s = 32767;
         acc = clamp16(acc + s);
      end
      return 16'(acc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      for (int k = 0; k < TAPS; k++) m_x[k] = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_busy     = 1'b0;
            m_have_out = 1'b0;
            for (int k = 0; k < TAPS; k++) m_x[k] = 0;
         end else begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (m_have_out && out_ready) begin
               m_have_out = 1'b0;
               m_busy     = 1'b0;
            end else if (m_busy && !m_have_out && cyc == m_acc_cyc + TAPS) begin
               m_have_out = 1'b1;
            end else if (!m_busy && in_valid) begin
               for (int k = TAPS-1; k > 0; k--) m_x[k] = m_x[k-1];
               m_x[0]    = $signed(in_data);
               m_exp     = fir_ref(coefs, m_x);
               m_busy    = 1'b1;
               m_acc_cyc = cyc;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("in_ready", 32'(in_ready), 32'(!rst && !m_busy));
         chk("out_valid", 32'(out_valid), 32'(m_have_out));
         if (m_have_out) chk("out_data", 32'(out_data), 32'(m_exp));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int k = 0; k < TAPS; k++) coefs[k*W +: W] = v;
   endtask

   task automatic send(input logic [15:0] d);
      int n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      chk("send_wait_in_ready", 32'(in_ready), 32'h1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      chk("drain_in_ready", 32'(in_ready), 32'h1);
   endtask

   task automatic expect_out(input string name, input int idx, input logic [15:0] v);
      logic [31:0] a;
      a = (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hxxxx_xxxx;
      chk(name, a, 32'(v));
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 4))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int base;
      int n;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      coefs     = '0;
      rst       = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
      tick();

      // Impulse through half-scale taps
      set_all(16'h4000);
      base = got_q.size();
      send(16'h7FFF);
      repeat (4) send(16'h0000);
      drain();
      for (int i = 0; i < 4; i++) expect_out("impulse", base + i, 16'h3FFF);
      expect_out("impulse_tail", base + 4, 16'h0000);

      // Positive saturation (delay line is all zero after the impulse)
      set_all(16'h7FFF);
      base = got_q.size();
      repeat (4) send(16'h7FFF);
      drain();
      expect_out("pos_sat0", base + 0, 16'h7FFE);
      expect_out("pos_sat1", base + 1, 16'h7FFF);
      expect_out("pos_sat3", base + 3, 16'h7FFF);

      // Negative saturation
      do_reset(2);
      set_all(16'h7FFF);
      base = got_q.size();
      repeat (2) send(16'h8000);
      drain();
      expect_out("neg_sat0", base + 0, 16'h8001);
      expect_out("neg_sat1", base + 1, 16'h8000);

      // min * min clamps positive
      do_reset(2);
      coefs = '0;
      coefs[W-1:0] = 16'h8000;
      base = got_q.size();
      send(16'h8000);
      drain();
      expect_out("min_x_min", base, 16'h7FFF);

      // Backpressure with junk on the input
      do_reset(2);
      set_all(16'h4000);
      out_ready = 1'b0;
      base = got_q.size();
      send(16'h7FFF);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_valid_rise", 32'(out_valid), 32'h1);
      for (int i = 0; i < 6; i++) begin
         in_valid = i[0];
         in_data  = 16'($urandom);
         tick();
         chk("bp_hold_data", 32'(out_data), 32'h3FFF);
         chk("bp_hold_valid", 32'(out_valid), 32'h1);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_in_ready_after", 32'(in_ready), 32'h1);
      send(16'h0000);
      drain();
      expect_out("bp_result", base, 16'h3FFF);
      expect_out("bp_no_junk", base + 1, 16'h3FFF);

      // Coefficients change while MAC runs
      do_reset(2);
      set_all(16'h4000);
      base = got_q.size();
      send(16'h7FFF);
      set_all(16'h1234);
      tick();
      set_all(16'h7FFF);
      drain();
      expect_out("coef_in_flight", base, 16'h3FFF);

      // Reset at tap index 2
      do_reset(2);
      set_all(16'h4000);
      base = got_q.size();
      send(16'h7FFF);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("rst_mac_no_out", 32'(got_q.size()), 32'(base));
      send(16'h7FFF);
      drain();
      expect_out("rst_mac_clean", base, 16'h3FFF);

      // Randomized traffic, backpressure and occasional reset
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = 1'($urandom);
         in_data   = pick();
         for (int k = 0; k < TAPS; k++) coefs[k*W +: W] = pick();
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
